// File: rtl/axi_rd_sram_responder_if.sv
// AXI4 read address / read data channel bundle between a read initiator (master)
// and a memory-side responder (slave).
interface axi_rd_sram_responder_if #(
  parameter int ID_W = 4
) ();
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;

  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_rd_sram_responder.sv
// AXI4 read responder backed by a word-addressed synchronous SRAM: one burst in
// flight, FIXED/INCR/WRAP addressing, programmable first-beat latency, SLVERR/DECERR.
module axi_rd_sram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_AW    = 16,
  parameter int          ID_W      = 4,
  parameter int          LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  axi_rd_sram_responder_if.slave s,
  output logic                 mem_en,
  output logic [MEM_AW-1:0]    mem_addr,
  input  logic [31:0]          mem_rdata,
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    WAIT  = 4'b0010,
    FETCH = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic [1:0]  RESP_DECERR = 2'd3;
  localparam logic [32:0] WINDOW      = 33'd4 << MEM_AW;
  localparam logic [7:0]  LAT_INIT    = 8'(LATENCY);

  state_t          state, state_next;
  logic            run;
  logic [31:0]     addr, addr_next, offset, step, wrap_mask;
  logic [ID_W-1:0] id;
  logic [7:0]      len, beat, cnt;
  logic [2:0]      size;
  logic [1:0]      burst;
  logic            slverr, ar_bad, in_range, last_beat;
  logic            ar_hs, r_hs;

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both 1. Once rvalid is raised, it and the R payload hold until rready.
  // arready/rvalid depend only on state and reset, never on arvalid/rready.
  assign run   = reset;
  assign ar_hs = s.arready & s.arvalid;
  assign r_hs  = s.rvalid & s.rready;

  assign ar_bad = (s.arsize > 3'd2) || (s.arburst == 2'd3) ||
                  ((s.arburst == 2'd2) &&
                   !((s.arlen == 8'd1) || (s.arlen == 8'd3) ||
                     (s.arlen == 8'd7) || (s.arlen == 8'd15)));

  assign offset    = addr - ADDR_BASE;
  assign in_range  = {1'b0, offset} < WINDOW;
  assign last_beat = (beat == len);

  assign step      = 32'd1 << size;
  assign wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;

  always_comb begin
    addr_next = addr;
    case (burst)
      2'd1:    addr_next = addr + step;
      2'd2:    addr_next = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default: addr_next = addr;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s.arvalid) state_next = (LATENCY == 0) ? FETCH : WAIT;
      WAIT:    if (cnt == 8'd1) state_next = FETCH;
      FETCH:   state_next = RESP;
      RESP:    if (s.rready) state_next = last_beat ? IDLE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      addr   <= '0;
      id     <= '0;
      len    <= '0;
      size   <= '0;
      burst  <= '0;
      beat   <= '0;
      cnt    <= '0;
      slverr <= 1'b0;
    end else begin
      if (ar_hs) begin
        addr   <= s.araddr;
        id     <= s.arid;
        len    <= s.arlen;
        size   <= s.arsize;
        burst  <= s.arburst;
        beat   <= '0;
        cnt    <= LAT_INIT;
        slverr <= ar_bad;
      end
      if (state == WAIT) cnt <= cnt - 8'd1;
      if (r_hs && !last_beat) begin
        beat <= beat + 8'd1;
        addr <= addr_next;
      end
    end
  end

  // mem_rdata is held by the SRAM while mem_en is low, so it stays valid in RESP.
  assign mem_en   = run && (state == FETCH) && !slverr && in_range;
  assign mem_addr = offset[MEM_AW+1:2];

  always_comb begin
    s.arready = run && (state == IDLE);
    s.rvalid  = run && (state == RESP);
    s.rresp   = RESP_OKAY;
    s.rdata   = '0;
    s.rlast   = 1'b0;
    s.rid     = '0;
    if (s.rvalid) begin
      if (slverr)        s.rresp = RESP_SLVERR;
      else if (!in_range) s.rresp = RESP_DECERR;
      s.rdata = (s.rresp == RESP_OKAY) ? mem_rdata : 32'd0;
      s.rlast = last_beat;
      s.rid   = id;
    end
  end

  assign dbg_state = state;

endmodule
